// File: rtl/fpnew_slice_result_arbiter.sv
// fpnew_slice_result_arbiter: round-robin merge of per-format slice results into one registered output
module fpnew_slice_result_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 64,
  parameter int TAG_WIDTH  = 8,
  localparam int PW        = $clog2(NUM_INPUTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_INPUTS-1:0]           in_valid_i,
  output logic [NUM_INPUTS-1:0]           in_ready_o,
  input  logic [NUM_INPUTS*WIDTH-1:0]     in_result_i,
  input  logic [NUM_INPUTS*5-1:0]         in_status_i,
  input  logic [NUM_INPUTS-1:0]           in_ext_bit_i,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0] in_tag_i,
  input  logic                            flush_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [WIDTH-1:0]                result_o,
  output logic [4:0]                      status_o,
  output logic                            extension_bit_o,
  output logic [TAG_WIDTH-1:0]            tag_o,
  output logic [PW-1:0]                   out_src_o,
  output logic                            busy_o
);
  logic [PW-1:0] ptr, g, c;
  logic          any_valid, slot_free, accept;
  assign any_valid = |in_valid_i;
  assign slot_free = !out_valid_o || out_ready_i;
  assign accept    = slot_free && !flush_i && !rst_i && any_valid;
  assign busy_o    = out_valid_o || any_valid;
  // scan from ptr+N-1 down to ptr so the first valid index at or after ptr wins
  always_comb begin
    g = '0;
    c = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      c = PW'((int'(ptr) + k) % NUM_INPUTS);
      if (in_valid_i[c]) g = c;
    end
  end
  // only the winner is told it was taken, and only when the slot can load
  always_comb begin
    in_ready_o = '0;
    if (accept) in_ready_o[g] = 1'b1;
  end
  // output register and rotating priority pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o     <= 1'b0;
      ptr             <= '0;
      result_o        <= '0;
      status_o        <= '0;
      extension_bit_o <= 1'b0;
      tag_o           <= '0;
      out_src_o       <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (slot_free) begin
      out_valid_o <= any_valid;
      if (any_valid) begin
        result_o        <= in_result_i[int'(g)*WIDTH +: WIDTH];
        status_o        <= in_status_i[int'(g)*5 +: 5];
        extension_bit_o <= in_ext_bit_i[g];
        tag_o           <= in_tag_i[int'(g)*TAG_WIDTH +: TAG_WIDTH];
        out_src_o       <= g;
        ptr             <= (g == PW'(NUM_INPUTS - 1)) ? '0 : g + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpnew_slice_result_arbiter.sv
// tb_fpnew_slice_result_arbiter: directed checks of the slice result arbiter
module tb_fpnew_slice_result_arbiter;
  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid, in_ready, in_ext;
  logic [255:0]  in_result;
  logic [19:0]   in_status;
  logic [31:0]   in_tag;
  logic          flush, out_valid, out_ready, ext_bit, busy;
  logic [63:0]   result;
  logic [4:0]    status;
  logic [7:0]    tag;
  logic [1:0]    src;
  logic [63:0]   res [4];
  logic [7:0]    tg [4];
  logic [4:0]    st [4];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_result[k*64 +: 64] = res[k];
      in_tag[k*8 +: 8]      = tg[k];
      in_status[k*5 +: 5]   = st[k];
    end
  end

  fpnew_slice_result_arbiter dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_result_i(in_result), .in_status_i(in_status), .in_ext_bit_i(in_ext),
    .in_tag_i(in_tag), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .status_o(status),
    .extension_bit_o(ext_bit), .tag_o(tag), .out_src_o(src), .busy_o(busy)
  );

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      res[k] = 64'h1000 + 64'(k);
      tg[k]  = 8'h20 + 8'(k);
      st[k]  = 5'd0;
    end
    in_ext = 4'b0; rst = 1'b1; in_valid = 4'b0; flush = 1'b0; out_ready = 1'b0;
    drive_edge();
    @(negedge clk);
    in_valid = 4'b1111;
    #1 chk("rst_ready", 64'(in_ready), 64'h0);
    drive_edge();
    @(negedge clk);
    in_valid = 4'b0;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_result", result, 64'h0);
    chk("rst_tag", 64'(tag), 64'h0);
    chk("rst_src", 64'(src), 64'h0);
    chk("rst_ptr", 64'(dut.ptr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    // single accept from slice 2
    @(negedge clk);
    res[2] = 64'h3FF0000000000000; tg[2] = 8'h11;
    in_valid = 4'b0100; out_ready = 1'b1;
    #1 chk("one_ready", 64'(in_ready), 64'h4);
    drive_edge();
    chk("one_valid", 64'(out_valid), 64'h1);
    chk("one_result", result, 64'h3FF0000000000000);
    chk("one_tag", 64'(tag), 64'h11);
    chk("one_src", 64'(src), 64'h2);
    chk("one_ptr", 64'(dut.ptr), 64'h3);
    // idle slot clears valid, data holds
    @(negedge clk);
    in_valid = 4'b0;
    drive_edge();
    chk("idle_valid", 64'(out_valid), 64'h0);
    chk("idle_hold", result, 64'h3FF0000000000000);
    // wrap from index 3 back to ptr 0
    @(negedge clk);
    in_valid = 4'b1000;
    drive_edge();
    chk("wrap_ptr", 64'(dut.ptr), 64'h0);
    res[2] = 64'h1002; tg[2] = 8'h22;
    // all valid: rotating grants 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 4'b1111;
      #1 chk("rr_ready", 64'(in_ready), 64'(4'b0001 << (i % 4)));
      drive_edge();
      chk("rr_src", 64'(src), 64'(i % 4));
      chk("rr_result", result, 64'h1000 + 64'(i % 4));
    end
    chk("rr_ptr", 64'(dut.ptr), 64'h1);
    // move ptr back to 0 via slice 3
    @(negedge clk);
    in_valid = 4'b1000;
    drive_edge();
    chk("p0_ptr", 64'(dut.ptr), 64'h0);
    // backpressure: outputs stable, nothing accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 4'b0011; out_ready = 1'b0;
      #1 chk("bp_ready", 64'(in_ready), 64'h0);
      drive_edge();
      chk("bp_valid", 64'(out_valid), 64'h1);
      chk("bp_result", result, 64'h1003);
      chk("bp_src", 64'(src), 64'h3);
      chk("bp_busy", 64'(busy), 64'h1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_release", 64'(in_ready), 64'h1);
    drive_edge();
    chk("bp_src0", 64'(src), 64'h0);
    chk("bp_ptr", 64'(dut.ptr), 64'h1);
    // flush overrides ready and accepts nothing
    @(negedge clk);
    in_valid = 4'b0010; flush = 1'b1; out_ready = 1'b1;
    #1 chk("fl_ready", 64'(in_ready), 64'h0);
    drive_edge();
    chk("fl_valid", 64'(out_valid), 64'h0);
    chk("fl_ptr", 64'(dut.ptr), 64'h1);
    chk("fl_result", result, 64'h1000);
    // status and extension bit pass-through
    @(negedge clk);
    flush = 1'b0; st[1] = 5'b00001; in_ext = 4'b0010;
    drive_edge();
    chk("st_status", 64'(status), 64'h1);
    chk("st_ext", 64'(ext_bit), 64'h1);
    chk("st_src", 64'(src), 64'h1);
    chk("st_ptr", 64'(dut.ptr), 64'h2);
    // reset with a held result overrides flush and ready
    @(negedge clk);
    in_valid = 4'b0; out_ready = 1'b0;
    drive_edge();
    chk("hold_valid", 64'(out_valid), 64'h1);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    drive_edge();
    chk("rr_valid0", 64'(out_valid), 64'h0);
    chk("rr_res0", result, 64'h0);
    chk("rr_stat0", 64'(status), 64'h0);
    chk("rr_ext0", 64'(ext_bit), 64'h0);
    chk("rr_tag0", 64'(tag), 64'h0);
    chk("rr_src0", 64'(src), 64'h0);
    chk("rr_ptr0", 64'(dut.ptr), 64'h0);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 4'b1010;
    #1 chk("post_rst_ready", 64'(in_ready), 64'h2);
    drive_edge();
    chk("post_rst_src", 64'(src), 64'h1);
    chk("post_rst_tag", 64'(tag), 64'h21);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpnew_slice_result_arbiter.md
FPNEW_SLICE_RESULT_ARBITER -- requirements
Module: fpnew_slice_result_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 4, giving the number of format-slice result ports (legal range 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 64, giving the result width.
REQ-003 The block SHALL have parameter TAG_WIDTH, default 8, giving the tag width.
REQ-004 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 in_valid_i  input  NUM_INPUTS  per-slice result valid.
REQ-007 in_ready_o  output  NUM_INPUTS  per-slice result accept.
REQ-008 in_result_i  input  NUM_INPUTS x WIDTH  per-slice result.
REQ-009 in_status_i  input  NUM_INPUTS x 5  per-slice status flags {NV,DZ,OF,UF,NX}.
REQ-010 in_ext_bit_i  input  NUM_INPUTS  per-slice extension bit.
REQ-011 in_tag_i  input  NUM_INPUTS x TAG_WIDTH  per-slice tag.
REQ-012 flush_i  input  1  discard the buffered result.
REQ-013 out_valid_o  output  1  registered result valid.
REQ-014 out_ready_i  input  1  downstream accept.
REQ-015 result_o / status_o / extension_bit_o / tag_o  outputs  WIDTH / 5 / 1 / TAG_WIDTH  registered winning result fields.
REQ-016 out_src_o  output  $clog2(NUM_INPUTS)  index of the slice that produced the registered result.
REQ-017 busy_o  output  1  result held or pending.

Function
REQ-018 The block SHALL hold one output register; a transfer out occurs when out_valid_o & out_ready_i.
REQ-019 The output register SHALL be loadable ("slot free") in a cycle when out_valid_o is 0 or out_ready_i is 1, giving full throughput of one result per cycle.
REQ-020 Arbitration SHALL be round-robin: the winner is the first asserted in_valid_i index at or above pointer ptr, wrapping from NUM_INPUTS-1 to 0.
REQ-021 in_ready_o SHALL be one-hot or zero: only the winner's bit is 1, and only when the slot is free and flush_i is 0; this is combinational.
REQ-022 On acceptance, the winner's result, status, ext bit, tag and index SHALL be registered; out_valid_o is 1 the next cycle (latency 1 cycle).
REQ-023 After acceptance from index g, ptr SHALL become (g+1) mod NUM_INPUTS; with no acceptance, ptr holds.
REQ-024 A slot free with no in_valid_i SHALL clear out_valid_o; the data registers hold their values.
REQ-025 While out_valid_o=1 and out_ready_i=0, all outputs SHALL stay stable and in_ready_o SHALL be all-zero.
REQ-026 flush_i=1 SHALL clear out_valid_o the next cycle, accept nothing that cycle, and leave ptr unchanged; flush_i overrides out_ready_i.
REQ-027 A non-winning valid input SHALL be held by its slice; the block SHALL NOT drop or reorder per-slice results.
REQ-028 busy_o SHALL equal out_valid_o OR (|in_valid_i).
REQ-029 in_valid_i bits asserted together SHALL be served in rotating order starting at ptr, with no starvation: each waiting input is granted within NUM_INPUTS accepts.

Reset
REQ-030 While rst_i=1 at a clock edge, the block SHALL set out_valid_o=0, ptr=0, result_o=0, status_o=0, extension_bit_o=0, tag_o=0 and out_src_o=0.
REQ-031 During reset, in_ready_o SHALL be all-zero.
REQ-032 Reset asserted with a result held SHALL discard that result and override flush_i and out_ready_i.

Verification
REQ-033 After reset, pulse in_valid_i=4'b0100 with result 0x3FF0000000000000 and tag 0x11, out_ready_i=1 -> in_ready_o=4'b0100 the same cycle; the next cycle out_valid_o=1, result_o=0x3FF0000000000000, tag_o=0x11, out_src_o=2; ptr=3.
REQ-034 Hold in_valid_i=4'b1111 with out_ready_i=1 from ptr=0 -> grants in order 0,1,2,3,0, one per cycle; out_src_o follows one cycle later.
REQ-035 out_valid_o=1, out_ready_i=0 for 3 cycles with in_valid_i=4'b0011 -> in_ready_o=0 and outputs stable; on out_ready_i=1, in_ready_o=4'b0001 that cycle.
REQ-036 Assert flush_i with out_valid_o=1 and in_valid_i=4'b0010 -> in_ready_o=0 that cycle, out_valid_o=0 the next cycle, ptr unchanged.
REQ-037 in_status_i[1]=5'b00001 accepted -> status_o=5'b00001 and extension_bit_o equal to in_ext_bit_i[1] on the output cycle.
REQ-038 Assert rst_i while out_valid_o=1 and out_ready_i=0 -> the next cycle out_valid_o=0 and all outputs zero, and the first grant after reset goes to the lowest valid index.
